// File: rtl/video_stream_arbiter_if.sv
// video_stream_arbiter_if: two Avalon-ST pixel sources plus the DMA sink port.
// The master modport is the arbiter; the slave modport is the surrounding system.
interface video_stream_arbiter_if #(parameter int DATA_W = 24);
    logic [DATA_W-1:0] a_data, b_data, out_data;
    logic              a_sop, a_eop, a_valid, a_ready;
    logic              b_sop, b_eop, b_valid, b_ready;
    logic              out_sop, out_eop, out_valid, out_ready;
    modport master (
        input  a_data, a_sop, a_eop, a_valid, b_data, b_sop, b_eop, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_sop, out_eop, out_valid
    );
    modport slave (
        output a_data, a_sop, a_eop, a_valid, b_data, b_sop, b_eop, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_sop, out_eop, out_valid
    );
endinterface

// File: rtl/video_stream_arbiter.sv
// video_stream_arbiter: packet-atomic 2:1 Avalon-ST arbiter with a registered
// output stage, per-source frame counters and a sticky mid-packet stall flag.
module video_stream_arbiter #(
    parameter int DATA_W      = 24,
    parameter int STALL_LIMIT = 1024,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    video_stream_arbiter_if.master bus,
    input  logic [1:0]             mode,
    input  logic                   err_clr,
    output logic [1:0]             grant,
    output logic [CNT_W-1:0]       frames_a,
    output logic [CNT_W-1:0]       frames_b,
    output logic                   stall_err
);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t              r_state, w_next;
    logic                r_last_b;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_sop, r_out_eop, r_out_valid;
    logic [CNT_W-1:0]    r_frames_a, r_frames_b;
    logic [SW-1:0]       r_stall_cnt;
    logic                r_stall_err;
    logic                w_adv, w_ca, w_cb, w_pick_a, w_pick_b;
    logic                w_acc_a, w_acc_b, w_beat, w_gvalid, w_stall_inc, w_stall_set;

    assign w_adv    = ~r_out_valid | bus.out_ready;
    assign w_ca     = bus.a_valid & bus.a_sop;
    assign w_cb     = bus.b_valid & bus.b_sop;
    // r_last_b resets high so A wins the first round-robin tie
    assign w_pick_a = (mode == 2'b00) ? w_ca & (~w_cb | r_last_b) : (mode == 2'b01) & w_ca;
    assign w_pick_b = (mode == 2'b00) ? w_cb & (~w_ca | ~r_last_b) : (mode == 2'b10) & w_cb;
    assign w_acc_a  = (r_state == GRANT_A) & bus.a_valid & bus.a_ready;
    assign w_acc_b  = (r_state == GRANT_B) & bus.b_valid & bus.b_ready;
    assign w_beat   = w_acc_a | w_acc_b;
    assign w_gvalid = (r_state == GRANT_A) ? bus.a_valid : bus.b_valid;
    // Counter saturates at the limit so err_clr is not immediately overridden
    assign w_stall_inc = (r_state != IDLE) & ~w_gvalid & (r_stall_cnt != SW'(STALL_LIMIT));
    assign w_stall_set = w_stall_inc & (r_stall_cnt == SW'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pick_a ? GRANT_A : w_pick_b ? GRANT_B : IDLE;
            GRANT_A: w_next = (w_acc_a & bus.a_eop) ? IDLE : GRANT_A;
            GRANT_B: w_next = (w_acc_b & bus.b_eop) ? IDLE : GRANT_B;
            default: w_next = IDLE;
        endcase
    end

    // In IDLE, orphan non-sop beats are drained; sop beats wait for the grant
    always_comb begin
        bus.a_ready = (r_state == GRANT_A) ? w_adv : (r_state == IDLE) & bus.a_valid & ~bus.a_sop;
        bus.b_ready = (r_state == GRANT_B) ? w_adv : (r_state == IDLE) & bus.b_valid & ~bus.b_sop;
        grant       = {r_state == GRANT_B, r_state == GRANT_A};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b    <= 1'b1;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_valid <= 1'b0;
            r_frames_a  <= '0;
            r_frames_b  <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (r_state == IDLE && (w_pick_a || w_pick_b)) r_last_b <= w_pick_b;
            if (w_adv) begin
                r_out_valid <= w_beat;
                if (w_beat) begin
                    r_out_data <= w_acc_a ? bus.a_data : bus.b_data;
                    r_out_sop  <= w_acc_a ? bus.a_sop : bus.b_sop;
                    r_out_eop  <= w_acc_a ? bus.a_eop : bus.b_eop;
                end
            end
            if (w_acc_a && bus.a_eop) r_frames_a <= r_frames_a + 1'b1;
            if (w_acc_b && bus.b_eop) r_frames_b <= r_frames_b + 1'b1;
            r_stall_cnt <= (r_state == IDLE || w_beat) ? '0 : w_stall_inc ? r_stall_cnt + 1'b1 : r_stall_cnt;
            r_stall_err <= w_stall_set ? 1'b1 : err_clr ? 1'b0 : r_stall_err;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_valid = r_out_valid;
    assign frames_a      = r_frames_a;
    assign frames_b      = r_frames_b;
    assign stall_err     = r_stall_err;
endmodule
